// File: rtl/mem_pkg.sv
// Shared constants and types for the block mover.
// ADDR_W/DATA_W size the 16K x 16 dual-port RAM; mode_t selects copy or fill;
// state_t is the control FSM encoding.
package mem_pkg;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_WORDS = 16384;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/mem_block_mover.sv
// Block mover: copies a word range (src -> dst) or fills a range with a constant.
// Reads go out on RAM port A (1-cycle synchronous read), writes go out on port B.
// A running 16-bit checksum and a count of committed writes are kept.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, mode           request pulse (sampled in idle), 0 = copy / 1 = fill
//   src_addr, dst_addr    first source / destination address (latched at start)
//   length, fill_value    word count and fill constant (latched at start)
//   abort                 stop a transfer in progress
//   busy, done, aborted   status; done/aborted are 1-cycle pulses
//   checksum, words_done  sum of written words (mod 2^16), count of writes
//   mem_a_*               RAM port A (read only; we/in tied low)
//   mem_b_*               RAM port B (write only; mem_b_out unused)
module mem_block_mover
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] words_done,
  output logic [ADDR_W-1:0] mem_a_address,
  output logic              mem_a_we,
  output logic [DATA_W-1:0] mem_a_in,
  input  logic [DATA_W-1:0] mem_a_out,
  output logic [ADDR_W-1:0] mem_b_address,
  output logic              mem_b_we,
  output logic [DATA_W-1:0] mem_b_in,
  input  logic [DATA_W-1:0] mem_b_out
);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] rd_next_q;   // next source address to issue
  logic [ADDR_W-1:0] wr_addr_q;   // next destination address to write
  logic [ADDR_W-1:0] remain_q;    // reads still to issue after the current one
  logic              drain_q;
  logic              issue_v_q;   // port A address this cycle belongs to the transfer
  logic              data_v_q;    // mem_a_out this cycle belongs to the transfer
  logic              busy_q, done_q, aborted_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q, words_q;
  logic              b_we_q;
  logic [DATA_W-1:0] b_data_q, sum_q;

  logic launch, run_issue, rd_issue, abort_fire;

  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    run_issue  = 1'b0;
    abort_fire = abort & busy_q;
    unique case (state_q)
      ST_IDLE: begin
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          launch  = 1'b1;
          state_d = (length == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_fire)            state_d   = ST_IDLE;
        else if (remain_q != '0)   run_issue = 1'b1;
        else                       state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_fire)   state_d = ST_IDLE;
        else if (drain_q) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // the first read goes out on the start edge itself
    rd_issue = run_issue | (launch & (length != '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_FINISH);
      aborted_q <= abort_fire;
      drain_q   <= (state_q == ST_DRAIN) && (state_d == ST_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_COPY;
      fill_q    <= '0;
      rd_next_q <= '0;
      wr_addr_q <= '0;
      remain_q  <= '0;
      issue_v_q <= 1'b0;
      data_v_q  <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      b_we_q    <= 1'b0;
      b_data_q  <= '0;
      sum_q     <= '0;
      words_q   <= '0;
    end else begin
      // two-stage pipe: address out -> data back -> write out
      issue_v_q <= rd_issue;
      data_v_q  <= issue_v_q & ~abort_fire;
      b_we_q    <= data_v_q & ~abort_fire;
      if (data_v_q) begin
        b_addr_q  <= wr_addr_q;
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
        b_data_q  <= (mode_q == MODE_FILL) ? fill_q : mem_a_out;
      end

      if (launch) begin
        mode_q    <= mode_t'(mode);
        fill_q    <= fill_value;
        rd_next_q <= src_addr + ADDR_W'(1);
        remain_q  <= length - ADDR_W'(1);
        wr_addr_q <= dst_addr;
        // fill leaves the read address where it was
        if (mode_t'(mode) == MODE_COPY) a_addr_q <= src_addr;
      end else if (run_issue) begin
        remain_q  <= remain_q - ADDR_W'(1);
        rd_next_q <= rd_next_q + ADDR_W'(1);
        if (mode_q == MODE_COPY) a_addr_q <= rd_next_q;
      end

      if (launch) begin
        sum_q   <= '0;
        words_q <= '0;
      end else if (b_we_q) begin
        sum_q   <= sum_q + b_data_q;
        words_q <= words_q + ADDR_W'(1);
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign checksum      = sum_q;
  assign words_done    = words_q;
  assign mem_a_address = a_addr_q;
  assign mem_a_we      = 1'b0;
  assign mem_a_in      = '0;
  assign mem_b_address = b_addr_q;
  assign mem_b_we      = b_we_q;
  assign mem_b_in      = b_data_q;

  logic unused_b_out;
  assign unused_b_out = ^mem_b_out;

endmodule

// File: tb/tb_mem_block_mover.sv
module tb_mem_block_mover;
  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int WORDS = 16384;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, length = '0;
  logic [DW-1:0] fill_value = '0;
  logic          busy, done, aborted;
  logic [DW-1:0] checksum;
  logic [AW-1:0] words_done, mem_a_address, mem_b_address;
  logic          mem_a_we, mem_b_we;
  logic [DW-1:0] mem_a_in, mem_a_out, mem_b_in, mem_b_out;

  // bench-side RAM with a preload port
  logic [DW-1:0] ram   [WORDS];
  logic [DW-1:0] model [WORDS];
  logic [DW-1:0] pre   [WORDS];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, s_cyc = 0;
  int first_we, we_cnt, done_cnt, done_rel, ab_cnt, ab_rel;
  logic busy_first, busy_done, busy_ab;

  always #5 clk = ~clk;
  assign mem_b_out = '0;

  mem_block_mover dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .checksum(checksum), .words_done(words_done),
    .mem_a_address(mem_a_address), .mem_a_we(mem_a_we), .mem_a_in(mem_a_in),
    .mem_a_out(mem_a_out), .mem_b_address(mem_b_address), .mem_b_we(mem_b_we),
    .mem_b_in(mem_b_in), .mem_b_out(mem_b_out)
  );

  always @(posedge clk) begin
    mem_a_out <= ram[mem_a_address];
    if (mem_b_we) ram[mem_b_address] <= mem_b_in;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // event monitor; rel = k means "cycle after edge S+k"
  always @(negedge clk) begin
    int rel;
    rel = cyc - s_cyc;
    if (mem_b_we) begin
      we_cnt++;
      if (first_we < 0) first_we = rel;
    end
    if (done) begin done_cnt++; done_rel = rel; busy_done = busy; end
    if (aborted) begin ab_cnt++; ab_rel = rel; busy_ab = busy; end
    if (rel == 0) busy_first = busy;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a[AW-1:0]; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    model[a] = d;
  endtask

  task automatic resync();
    for (int i = 0; i < WORDS; i++) model[i] = ram[i];
  endtask

  // One transfer; abort_at = a means abort sampled at edge S+a (<=0: none);
  // restart_at = j drives a second start in the cycle after edge S+j (<0: none).
  task automatic run_xfer(input string name, input bit m, input int src, input int dst,
                          input int len, input logic [DW-1:0] fill, input int abort_at,
                          input int restart_at);
    int nw, diffs;
    logic [DW-1:0] v, cs;
    bit ab;
    ab = (abort_at > 0);
    for (int i = 0; i < WORDS; i++) pre[i] = model[i];
    @(negedge clk);
    mode = m; src_addr = 14'(src); dst_addr = 14'(dst); length = 14'(len);
    fill_value = fill; start = 1'b1;
    first_we = -1; we_cnt = 0; done_cnt = 0; done_rel = -1; ab_cnt = 0; ab_rel = -1;
    busy_first = 1'b0; busy_done = 1'b1; busy_ab = 1'b1;
    @(posedge clk);
    #1 s_cyc = cyc;
    @(negedge clk);
    for (int i = 0; i < len + 12; i++) begin
      start = (i == restart_at);
      if (start) dst_addr = 14'(dst + 64);
      abort = (i == abort_at - 1);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;

    // reference: write k lands at dst+k, counted if committed by the abort edge
    nw = len;
    if (ab) begin
      nw = abort_at - 2;
      if (nw < 0) nw = 0;
      if (nw > len) nw = len;
    end
    cs = '0;
    for (int k = 0; k < nw; k++) begin
      v = m ? fill : pre[(src + k) % WORDS];
      model[(dst + k) % WORDS] = v;
      cs = cs + v;
    end
    diffs = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== model[i]) diffs++;

    check({name, ".done_cnt"}, done_cnt, ab ? 0 : 1);
    check({name, ".done_rel"}, done_rel, ab ? -1 : (len == 0 ? 0 : len + 2));
    check({name, ".aborted_cnt"}, ab_cnt, ab ? 1 : 0);
    if (ab) begin
      check({name, ".aborted_rel"}, ab_rel, abort_at);
      check({name, ".busy_at_abort"}, busy_ab, 0);
    end else begin
      check({name, ".busy_at_done"}, busy_done, 0);
    end
    check({name, ".busy_first"}, busy_first, (len > 0) ? 1 : 0);
    check({name, ".first_we"}, first_we, (nw > 0) ? 2 : -1);
    check({name, ".we_cycles"}, we_cnt, nw);
    check({name, ".checksum"}, checksum, cs);
    check({name, ".words_done"}, words_done, nw);
    check({name, ".mem_diffs"}, diffs, 0);
  endtask

  initial begin
    bit m;
    int len, src, dst, ab;
    resync();
    repeat (2) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.we", mem_b_we, 0);
    check("reset.sum_cnt", {checksum, words_done}, 0);
    reset_n = 1'b1;

    // copy normal
    for (int k = 0; k < 4; k++) preload('h10 + k, 16'(k + 1));
    run_xfer("copy", 1'b0, 'h10, 'h100, 4, 16'h0, -1, -1);
    for (int k = 0; k < 4; k++) check("copy.dst_word", ram['h100 + k], k + 1);
    check("copy.sum_const", checksum, 16'h000A);

    // fill across the address wrap
    run_xfer("fill_wrap", 1'b1, 0, 'h3FFE, 3, 16'hA5A5, -1, -1);
    check("fill_wrap.w0000", ram[0], 16'hA5A5);
    check("fill_wrap.w0001", ram[1], pre[1]);
    check("fill_wrap.sum_const", checksum, 16'hF0EF);

    // zero length
    run_xfer("len0", 1'b0, 5, 'h200, 0, 16'h1234, -1, -1);

    // abort sampled at S+4
    for (int k = 0; k < 8; k++) preload('h20 + k, 16'($urandom));
    run_xfer("abort", 1'b0, 'h20, 'h300, 8, 16'h0, 4, -1);

    // second start while busy is ignored
    run_xfer("start_busy", 1'b1, 0, 'h400, 4, 16'h5A5A, -1, 1);

    // start together with abort in idle
    @(negedge clk);
    we_cnt = 0; length = 14'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort.busy", busy, 0);
    repeat (6) @(negedge clk);
    check("start_abort.we_cycles", we_cnt, 0);

    // reset in the middle of a copy
    @(negedge clk);
    mode = 1'b0; src_addr = 14'h0500; dst_addr = 14'h0600; length = 14'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst.busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.we", mem_b_we, 0);
    check("midrst.others", {done, aborted, checksum, words_done, mem_a_address,
                            mem_b_address, mem_b_in}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    resync();
    preload('h700, 16'hBEEF);
    run_xfer("after_rst", 1'b0, 'h700, 'h710, 1, 16'h0, -1, -1);

    // randomized transfers with non-overlapping ranges
    for (int t = 0; t < 6; t++) begin
      m   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 24));
      src = int'($urandom_range(0, WORDS - 1));
      dst = (src + len + int'($urandom_range(0, 6000))) % WORDS;
      if (!m) for (int k = 0; k < len; k++) preload((src + k) % WORDS, 16'($urandom));
      ab = (t >= 4) ? int'($urandom_range(1, len + 2)) : -1;
      run_xfer("rand", m, src, dst, len, 16'($urandom), ab, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Initiator/DMA engine that drives both ports of the shared 16K x 16 dual-port block RAM.
- Port A is the read port; port B is the write port.
- Copies a range of words (src to dst) or fills a range with a constant.
- Sits between the CPU's control registers and the memory. It accounts for the RAM's 1-cycle synchronous read latency and accumulates a 16-bit checksum of the words written.

Parameters:
- ADDR_W, 14, memory address width; all addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = COPY, 1 = FILL; latched at start.
- src_addr  in  ADDR_W  first source address (COPY only); latched at start.
- dst_addr  in  ADDR_W  first destination address; latched at start.
- length  in  ADDR_W  word count, 0..16383; latched at start.
- fill_value  in  DATA_W  constant for FILL; latched at start.
- abort  in  1  stop the transfer in progress.
- busy  out  1  transfer in progress.
- done  out  1  1-cycle pulse on normal completion.
- aborted  out  1  1-cycle pulse on abort completion.
- checksum  out  DATA_W  running sum of words written, mod 2^16.
- words_done  out  ADDR_W  count of writes committed.
- mem_a_address  out  ADDR_W  read address to the memory's port A.
- mem_a_we  out  1  held at 0.
- mem_a_in  out  DATA_W  held at 0.
- mem_a_out  in  DATA_W  read data from port A, valid the cycle after the address edge.
- mem_b_address  out  ADDR_W  write address to port B.
- mem_b_we  out  1  write strobe to port B.
- mem_b_in  out  DATA_W  write data to port B.
- mem_b_out  in  DATA_W  unused.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, state IDLE, internal counters 0.
- States:
  - IDLE: waits for start.
  - RUN: issues one read per cycle for len cycles.
  - DRAIN: 2 cycles to flush the read/write pipeline.
  - FINISH: 1 cycle, then back to IDLE.
- Start, at edge S (start=1 in IDLE):
  - Latch all inputs.
  - Clear checksum and words_done.
  - Set busy=1.
  - If length=0, go straight to FINISH: done=1 in the cycle after S; no memory access.
- Pipeline, all outputs registered, for k = 0..len-1:
  - Cycle after edge S+k: mem_a_address = src+k (COPY), or held at the last value (FILL).
  - Cycle after edge S+k+2: mem_b_we=1, mem_b_address = dst+k, mem_b_in = captured mem_a_out (COPY) or fill_value (FILL). The RAM commits the word at edge S+k+3.
  - FILL uses the same 2-stage timing, so latency is mode-independent.
- Throughput: 1 word per cycle.
- Completion:
  - mem_b_we low from the cycle after edge S+len+2.
  - done=1 for exactly the cycle after edge S+len+2; busy=0 in that same cycle.
  - checksum and words_done are final when done is high, and hold until the next start.
- Checksum and count:
  - checksum += mem_b_in and words_done += 1 at each edge where mem_b_we=1.
  - Width: 16-bit wrap, no saturation.
- Address wrap: src+k and dst+k wrap from 0x3FFF to 0x0000.
- Abort, sampled while busy at edge T:
  - The write presented in the cycle ending at T commits and is counted.
  - From the cycle after T: mem_b_we=0, no further reads advance, the read in flight is discarded.
  - aborted=1 for one cycle; done is not asserted.
  - busy=0 in that cycle; return to IDLE.
- Simultaneous events:
  - start while busy: ignored.
  - abort in IDLE: ignored.
  - start and abort together in IDLE: abort wins and the start is ignored.
- Overlapping COPY ranges: data in the destination is unspecified. done, count and timing are still as above.
- Reset mid-transfer: mem_b_we drops asynchronously; partially written memory contents are left as they are.

Decomposition:
- Package mem_pkg holds:
  - ADDR_W = 14, DATA_W = 16.
  - mode enum {MODE_COPY, MODE_FILL}.
  - state enum {ST_IDLE, ST_RUN, ST_DRAIN, ST_FINISH}.
  - MEM_WORDS = 16384.
- Single module, no sub-module: the control FSM and the 2-stage pipe are small enough to stay together.

Test Plan:
- COPY normal:
  - Stimulus: preload 0x0010..0x0013 = 1,2,3,4; src=0x0010, dst=0x0100, len=4.
  - Required: 0x0100..0x0103 = 1,2,3,4; first mem_b_we in the cycle after S+2; done in the cycle after S+6; checksum=0x000A; words_done=4.
- FILL with wrap:
  - Stimulus: dst=0x3FFE, len=3, fill=0xA5A5.
  - Required: 0x3FFE, 0x3FFF and 0x0000 written with 0xA5A5; 0x0001 untouched; checksum=0xF0EF.
- length=0:
  - Required: done in the cycle after S; mem_b_we never asserted; checksum=0.
- Abort:
  - Stimulus: COPY len=8; abort sampled at edge S+4.
  - Required: exactly 2 words written (dst, dst+1); words_done=2; aborted pulses; done never asserted; busy=0 in the cycle after S+4.
- Start while busy:
  - Stimulus: second start with different dst during a len=4 FILL.
  - Required: ignored; only the original range is written; one done pulse.
- Reset mid-op:
  - Stimulus: reset_n=0 during RUN of a len=10 COPY.
  - Required: all outputs 0 immediately. A new len=1 transfer after release completes with normal latency.
